// File: rtl/ifu_pkg.sv
// Shared types and constants for the prefetching instruction-fetch unit.
package ifu_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } ifu_state_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;
  localparam logic [31:0] NOP              = 32'h0000_0013;

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous prefetch queue; flush empties it and wins over a same-cycle push or pop.
module ifu_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [WIDTH-1:0]        push_data,
  input  logic                    pop,
  input  logic                    flush,
  output logic [WIDTH-1:0]        head_data,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign empty     = (r_count == '0);
  assign full      = (r_count == (AW+1)'(DEPTH));
  assign count     = r_count;
  assign w_push    = push & ~full & ~flush;
  assign w_pop     = pop & ~empty & ~flush;
  // Head reads as zero while empty so the consumer never sees stale words.
  assign head_data = empty ? '0 : r_mem[r_rdPtr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction-fetch unit: one outstanding in-order request, prefetch queue ahead of decode,
// redirect flushes the queue and discards any response still in flight.
module ifu_prefetch
  import ifu_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC),
  parameter int              DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_resp_valid,
  input  logic [XLEN-1:0] mem_resp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc
);

  localparam int CW = $clog2(DEPTH) + 1;

  ifu_state_t        r_state;
  logic [XLEN-1:0]   r_fetchPc;
  logic [XLEN-1:0]   r_reqPc;
  logic [2*XLEN-1:0] w_head;
  logic [CW-1:0]     w_count;
  logic              w_full;
  logic              w_empty;
  logic              w_inFlight;
  logic              w_credit;
  logic              w_accept;
  logic              w_push;
  logic              w_unused;

  assign w_unused   = ^redirect_pc[1:0];

  // An outstanding request already owns one queue slot, so it needs one spare beyond it.
  assign w_inFlight = (r_state != REQ);
  assign w_credit   = w_inFlight ? (w_count < CW'(DEPTH - 1)) : ~w_full;

  assign mem_req_valid = ~rst & (r_state == REQ) & w_credit & ~redirect_valid;
  assign mem_req_addr  = r_fetchPc;
  assign w_accept      = mem_req_valid & mem_req_ready;
  assign w_push        = (r_state == WAIT) & mem_resp_valid & ~redirect_valid;

  assign inst_valid = ~w_empty;
  assign inst_pc    = w_head[2*XLEN-1:XLEN];
  assign inst       = w_head[XLEN-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= REQ;
      r_fetchPc <= RESET_PC;
      r_reqPc   <= '0;
    end else if (redirect_valid) begin
      r_fetchPc <= {redirect_pc[XLEN-1:2], 2'b00};
      if (r_state != REQ) begin
        r_state <= mem_resp_valid ? REQ : DROP;
      end
    end else begin
      unique case (r_state)
        REQ: begin
          if (w_accept) begin
            r_state   <= WAIT;
            r_fetchPc <= r_fetchPc + XLEN'(4);
            r_reqPc   <= r_fetchPc;
          end
        end
        WAIT: begin
          if (mem_resp_valid) begin
            r_state <= REQ;
          end
        end
        DROP: begin
          if (mem_resp_valid) begin
            r_state <= REQ;
          end
        end
        default: r_state <= REQ;
      endcase
    end
  end

  ifu_fifo #(
    .WIDTH (2 * XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data ({r_reqPc, mem_resp_data}),
    .pop       (inst_ready),
    .flush     (redirect_valid),
    .head_data (w_head),
    .count     (w_count),
    .full      (w_full),
    .empty     (w_empty)
  );

endmodule

// File: tb/tb_ifu_prefetch.sv
// Bench for ifu_prefetch: the bench acts as instruction memory and consumer, and tracks the
// expected queue contents, fetch address and outstanding request as plain queue/flags.
module tb_ifu_prefetch;

  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  ifu_prefetch #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } entry_t;

  entry_t      q[$];
  logic [31:0] acceptLog[$];
  logic [31:0] mFetchPc;
  logic [31:0] mPendPc;
  bit          mOutstanding;
  bit          mStale;
  int          mWait;

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int firstAcceptCycle = -1;

  int          pReady = 100;
  int          pInstReady = 0;
  int          pRedirect = 0;
  int          pSpurious = 0;
  int          latMin = 1;
  int          latMax = 1;
  bit          rstLevel = 1'b1;
  bit          forceRedirect = 1'b0;
  logic [31:0] forceTarget = '0;

  function automatic logic [31:0] memData(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1357_2468;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: actual=%h required=%h", name, cycle, act, exp);
    end
  endtask

  task automatic applyStimulus();
    rst = rstLevel;
    redirect_valid = forceRedirect || ($urandom_range(0, 99) < pRedirect);
    if (forceRedirect) begin
      redirect_pc = forceTarget;
    end else if ($urandom_range(0, 3) == 0) begin
      redirect_pc = 32'hFFFF_FFF4 | 32'($urandom_range(0, 3));
    end else begin
      redirect_pc = $urandom;
    end
    forceRedirect = 1'b0;
    mem_req_ready = ($urandom_range(0, 99) < pReady);
    inst_ready    = ($urandom_range(0, 99) < pInstReady);
    if (mOutstanding) begin
      mem_resp_valid = (mWait <= 1);
      mem_resp_data  = memData(mPendPc);
    end else begin
      mem_resp_valid = ($urandom_range(0, 99) < pSpurious);
      mem_resp_data  = $urandom;
    end
  endtask

  function automatic bit expReqValid();
    return !rst && !mOutstanding && (q.size() < DEPTH) && !redirect_valid;
  endfunction

  task automatic checkOutput();
    bit expReq;
    expReq = expReqValid();
    check("req_valid", mem_req_valid, expReq);
    if (expReq) check("req_addr", mem_req_addr, mFetchPc);
    check("inst_valid", inst_valid, (!rst && q.size() > 0));
    if (rst) begin
      check("inst_in_reset", inst, 32'h0);
      check("inst_pc_in_reset", inst_pc, 32'h0);
    end else if (q.size() > 0) begin
      check("inst_pc", inst_pc, q[0].pc);
      check("inst", inst, q[0].data);
    end
  endtask

  task automatic updateModel();
    bit accept, resp, pop;
    if (rst) begin
      q.delete();
      mOutstanding = 1'b0;
      mStale       = 1'b0;
      mFetchPc     = RESET_PC;
      return;
    end
    accept = expReqValid() && mem_req_ready;
    resp   = mOutstanding && mem_resp_valid;
    pop    = (q.size() > 0) && inst_ready;
    if (redirect_valid) begin
      q.delete();
      if (mOutstanding && !resp) mStale = 1'b1;
      mFetchPc = redirect_pc & ~32'h3;
    end else begin
      if (pop) void'(q.pop_front());
      if (resp && !mStale) q.push_back(entry_t'({mPendPc, mem_resp_data}));
      if (accept) begin
        acceptLog.push_back(mFetchPc);
        if (firstAcceptCycle < 0) firstAcceptCycle = cycle;
        mOutstanding = 1'b1;
        mStale       = 1'b0;
        mPendPc      = mFetchPc;
        mFetchPc     = mFetchPc + 32'd4;
        mWait        = $urandom_range(latMin, latMax);
      end
    end
    if (resp) begin
      mOutstanding = 1'b0;
      mStale       = 1'b0;
    end else if (mOutstanding && !accept) begin
      mWait--;
    end
  endtask

  task automatic stepCycle();
    @(negedge clk);
    cycle++;
    applyStimulus();
    #1;
    checkOutput();
    updateModel();
  endtask

  task automatic resetDut();
    pReady = 100; pInstReady = 0; pRedirect = 0; pSpurious = 0; latMin = 1; latMax = 1;
    rstLevel = 1'b1;
    stepCycle();
    stepCycle();
    rstLevel = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, actual=running required=done");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int validCycle;
    bit found;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0; mem_resp_data = '0; inst_ready = 1'b0;
    mFetchPc = RESET_PC; mPendPc = '0; mOutstanding = 1'b0; mStale = 1'b0; mWait = 0;

    // Streaming from reset with 1-cycle memory, consumer stalled until the queue fills.
    resetDut();
    acceptLog.delete();
    firstAcceptCycle = -1;
    validCycle = -1;
    for (int i = 0; i < 20 && validCycle < 0; i++) begin
      stepCycle();
      if (inst_valid === 1'b1) validCycle = cycle;
    end
    check("first_inst_latency", validCycle - firstAcceptCycle, 32'd2);
    check("first_inst_pc", inst_pc, 32'h8000_0000);
    for (int i = 0; i < 20; i++) stepCycle();
    check("request_count_full", acceptLog.size(), 32'd4);
    if (acceptLog.size() == 4) begin
      check("addr0", acceptLog[0], 32'h8000_0000);
      check("addr1", acceptLog[1], 32'h8000_0004);
      check("addr2", acceptLog[2], 32'h8000_0008);
      check("addr3", acceptLog[3], 32'h8000_000C);
    end
    check("full_req_low", mem_req_valid, 1'b0);
    check("full_inst_valid", inst_valid, 1'b1);

    // Redirect while waiting on a slow response; that response must be dropped.
    resetDut();
    latMin = 3; latMax = 3;
    for (int i = 0; i < 10 && !mOutstanding; i++) stepCycle();
    forceRedirect = 1'b1;
    forceTarget   = 32'h8000_0102;
    stepCycle();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      stepCycle();
      if (mem_req_valid === 1'b1) found = 1'b1;
    end
    check("redir_req_seen", found, 1'b1);
    check("redir_req_addr", mem_req_addr, 32'h8000_0100);
    check("redir_queue_empty", inst_valid, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      stepCycle();
      if (inst_valid === 1'b1) found = 1'b1;
    end
    check("redir_inst_pc", inst_pc, 32'h8000_0100);

    // Redirect colliding with a response and a pop in the same cycle.
    resetDut();
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (mOutstanding && mWait <= 1 && q.size() >= 1) found = 1'b1;
      else stepCycle();
    end
    check("collide_setup", found, 1'b1);
    forceRedirect = 1'b1;
    forceTarget   = 32'h0000_2000;
    pInstReady    = 100;
    stepCycle();
    pInstReady    = 0;
    stepCycle();
    check("collide_flushed", inst_valid, 1'b0);
    check("collide_req_valid", mem_req_valid, 1'b1);
    check("collide_req_addr", mem_req_addr, 32'h0000_2000);

    // Request held while memory stalls.
    resetDut();
    pReady = 0;
    for (int i = 0; i < 6; i++) begin
      stepCycle();
      check("hold_valid", mem_req_valid, 1'b1);
      check("hold_addr", mem_req_addr, 32'h8000_0000);
    end

    // Reset in the middle of a transaction, then late responses must be ignored.
    resetDut();
    latMin = 3; latMax = 3;
    for (int i = 0; i < 10 && !mOutstanding; i++) stepCycle();
    stepCycle();
    rstLevel = 1'b1;
    stepCycle();
    check("rst_req_valid", mem_req_valid, 1'b0);
    check("rst_inst_valid", inst_valid, 1'b0);
    check("rst_inst", inst, 32'h0);
    check("rst_inst_pc", inst_pc, 32'h0);
    pSpurious = 100;
    stepCycle();
    rstLevel = 1'b0;
    pSpurious = 60;
    stepCycle();
    check("restart_valid", mem_req_valid, 1'b1);
    check("restart_addr", mem_req_addr, 32'h8000_0000);
    for (int i = 0; i < 10; i++) stepCycle();

    // Randomised traffic under varying bus pressure, with occasional resets.
    for (int blk = 0; blk < 8; blk++) begin
      pReady     = $urandom_range(30, 100);
      pInstReady = $urandom_range(0, 100);
      pRedirect  = $urandom_range(0, 10);
      pSpurious  = $urandom_range(0, 30);
      latMin     = 1;
      latMax     = $urandom_range(1, 4);
      for (int i = 0; i < 400; i++) begin
        rstLevel = (blk % 2 == 1) && (i == 200 || i == 201);
        stepCycle();
      end
    end
    rstLevel = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
